// File: rtl/des_iter_ctrl_if.sv
// des_iter_ctrl_if: request/result handshake between the DES wrapper and the round sequencer
interface des_iter_ctrl_if;
    logic in_valid, in_dec, in_ready, out_valid, out_ready, abort, dec_mode, busy;
    modport master (
        output in_valid, in_dec, out_ready, abort,
        input  in_ready, out_valid, dec_mode, busy
    );
    modport slave (
        input  in_valid, in_dec, out_ready, abort,
        output in_ready, out_valid, dec_mode, busy
    );
endinterface

// File: rtl/des_iter_ctrl.sv
// des_iter_ctrl: sequences load, 16 rounds and final permutation of the iterative DES datapath
module des_iter_ctrl #(
    parameter int RND_CYCLES = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    des_iter_ctrl_if.slave bus,
    output logic           load_en,
    output logic           round_en,
    output logic           final_en,
    output logic [4:0]     round_idx,
    output logic [1:0]     key_shift,
    output logic           key_dir
);
    typedef enum logic [2:0] {IDLE, LOAD, ROUND, FINAL, DONE} state_t;
    state_t     state, state_n;
    logic [1:0] cnt, cnt_n;
    logic [4:0] idx_n;
    logic       dec, dec_n;
    logic       last;
    assign last = state == ROUND && cnt == 2'(RND_CYCLES - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            round_idx <= '0;
            dec       <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            round_idx <= idx_n;
            dec       <= dec_n;
        end
    end
    // abort wins over every transition, including round 16 completion and the result handshake
    always_comb begin
        state_n = state;
        cnt_n   = '0;
        idx_n   = '0;
        dec_n   = dec;
        if (bus.abort)
            state_n = IDLE;
        else
            case (state)
                IDLE: if (bus.in_valid) begin
                    state_n = LOAD;
                    dec_n   = bus.in_dec;
                end
                LOAD: begin
                    state_n = ROUND;
                    idx_n   = 5'd1;
                end
                ROUND: begin
                    cnt_n = last ? 2'd0 : cnt + 2'd1;
                    idx_n = last ? round_idx + 5'd1 : round_idx;
                    if (last && round_idx == 5'd16) begin
                        state_n = FINAL;
                        idx_n   = '0;
                    end
                end
                FINAL: state_n = DONE;
                DONE: if (bus.out_ready) state_n = IDLE;
                default: state_n = IDLE;
            endcase
    end
    assign bus.in_ready  = state == IDLE;
    assign bus.out_valid = state == DONE;
    assign bus.busy      = state != IDLE;
    assign bus.dec_mode  = dec;
    assign load_en       = state == LOAD;
    assign round_en      = last;
    assign final_en      = state == FINAL;
    assign key_dir       = dec;
    // decrypt starts from the fully rotated key, so round 1 needs no shift
    assign key_shift = state != ROUND ? 2'd0 :
                       (dec && round_idx == 5'd1) ? 2'd0 :
                       (round_idx inside {5'd1, 5'd2, 5'd9, 5'd16}) ? 2'd1 : 2'd2;
endmodule
